act_share_arbiter: RTL and testbench
====================================

Name: act_share_arbiter

Overview:
- Shares one pipelined activation unit (sigmoid or similar, fixed latency, valid-qualified) among NUM_REQ requesters.
- Round-robin arbitration issues at most one operand per cycle into the unit.
- A tag pipeline tracks which requester owns each in-flight operand. Each result is routed to a per-requester response register that holds it until accepted.
- Sits between the layer datapath lanes and a single activation instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 16, operand/result width, 2's complement, passed through unchanged
- ACT_LATENCY, 1, activation unit latency in cycles from act_valid to act_o_valid (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_en  in  1  global enable; when low no new grants, in-flight operands still drain
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed operands, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  operand accepted this cycle (one-hot or zero)
- rsp_valid  out  NUM_REQ  per-requester result valid
- rsp_data  out  NUM_REQ*DATA_WIDTH  packed results, same packing as req_data
- rsp_ready  in  NUM_REQ  per-requester result accept
- act_en  out  1  activation unit enable
- act_valid  out  1  operand valid to activation unit
- act_data  out  DATA_WIDTH  operand to activation unit
- act_o_valid  in  1  activation unit result valid
- act_o_data  in  DATA_WIDTH  activation unit result
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge): rsp_valid=0, rsp_data=0, busy flags=0, tag pipe cleared, err=0. Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Eligibility: requester i is eligible when req_valid[i] & ~busy[i] & i_en.
- busy[i] limits each requester to one outstanding item, either in flight or held in its response register. It therefore acts as a credit, and no result can ever find its slot occupied.
- Arbitration is combinational within the cycle. Search order starts at pointer+1 and wraps mod NUM_REQ; the first eligible requester wins.
- req_ready = one-hot grant. It depends combinationally on req_valid, which is permitted.
- On a grant to requester g:
  - act_valid=act_en=1 and act_data = req_data slice g, in the same cycle.
  - At the posedge: busy[g]=1, pointer=g, and tag stage 0 is loaded with {1, g}.
- With no grant: act_valid=act_en=0, act_data=0, tag stage 0 is loaded with {0, x}.
- Tag pipe: ACT_LATENCY stages of {valid, id[$clog2(NUM_REQ)-1:0]}, shifting every cycle regardless of i_en.
- Result capture: in a cycle where the last tag stage is valid and act_o_valid=1, the posedge sets rsp_data slice id = act_o_data and rsp_valid[id]=1.
- Latency: grant in cycle T, act_o_valid in cycle T+ACT_LATENCY, rsp_valid high from cycle T+ACT_LATENCY+1.
- Response handshake: rsp_valid[i] & rsp_ready[i] at a posedge clears rsp_valid[i] and busy[i]. rsp_data slice i holds its last value.
  - Requester i may be granted again in the cycle after the handshake, not the same cycle.
  - Peak rate per requester is one item per ACT_LATENCY+2 cycles. Aggregate rate is one item per cycle when NUM_REQ >= ACT_LATENCY+2.
- rsp_ready while rsp_valid=0 is ignored.
- Protocol check: err is set and held until rst on either condition:
  - act_o_valid=1 while the last tag stage is invalid;
  - the last tag stage is valid while act_o_valid=0.
- On error, the mismatched result is dropped and the tag is discarded. The owning busy flag stays set, so a stuck requester is visible.
- i_en falling mid-stream: no further grants; tags and results already issued complete normally.
- Reset mid-operation: all in-flight tags and held results are discarded; act_o_valid in the cycle after reset is ignored and not flagged.
- No arithmetic on data; width and format are passed through unchanged.

Test Plan:
- Single request: DATA_WIDTH=16, 5 fraction bits, ACT_LATENCY=1, activation = team sigmoid unit. req_valid=0001, req_data[0]=0x0000 at T0 -> req_ready=0001 at T0, act_valid=1 with act_data=0x0000 at T0, rsp_valid=0001 with rsp_data[0]=0x0010 at T2. With rsp_ready[0]=1 at T2, rsp_valid=0 at T3.
- Round-robin fairness: all four req_valid held high, rsp_ready all 1 -> grants 0,1,2,3 in T0..T3. Each requester is re-granted only after its response handshake; no requester is skipped twice.
- Backpressure: requester 1 wins with 0x0020, rsp_ready[1]=0 for 10 cycles -> rsp_valid[1] and rsp_data[1] held stable. req_ready[1] stays 0 despite req_valid[1]=1; other requesters keep being served.
- Enable gating: i_en drops the cycle after a grant to requester 2 -> no further grants, requester 2's result still arrives at rsp_valid[2]. Raising i_en resumes from pointer 3.
- Reset mid-flight: rst=1 in the cycle after a grant -> next cycle rsp_valid=0000, busy cleared, err=0, requester 0 has priority.
- Protocol error: force act_o_valid=1 with no issue outstanding -> err=1 next cycle and sticky, no rsp_valid asserted.

Source files
------------

// File: rtl/act_share_arbiter.sv
// act_share_arbiter: round-robin sharing of one pipelined activation unit
// among NUM_REQ requesters. A tag pipe remembers the owner of each in-flight
// operand so results land in the right per-requester response register.
// busy[i] is a one-item credit per requester, so a returning result never
// finds its response slot occupied.
module act_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACT_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic                          act_en,
  output logic                          act_valid,
  output logic [DATA_WIDTH-1:0]         act_data,
  input  logic                          act_o_valid,
  input  logic [DATA_WIDTH-1:0]         act_o_data,
  output logic                          err
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     busy;
  logic [IDW-1:0]         ptr;
  logic [ACT_LATENCY-1:0] tag_v;
  logic [IDW-1:0]         tag_id [ACT_LATENCY];
  logic                   post_rst;

  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     gnt;
  logic                   gnt_any;
  logic [IDW-1:0]         gnt_id;
  logic [IDW-1:0]         cand;

  logic                   last_v;
  logic [IDW-1:0]         last_id;
  logic                   capture;
  logic                   mismatch;

  assign elig = req_valid & ~busy & {NUM_REQ{i_en}};

  // Round-robin search starting just after the last winner; first eligible wins.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  // Drive the winning operand straight into the activation unit this cycle.
  always_comb begin
    req_ready = gnt;
    act_valid = gnt_any;
    act_en    = gnt_any;
    act_data  = '0;
    if (gnt_any) act_data = req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign last_v   = tag_v[ACT_LATENCY-1];
  assign last_id  = tag_id[ACT_LATENCY-1];
  assign capture  = last_v & act_o_valid;
  assign mismatch = (last_v ^ act_o_valid) & ~post_rst;

  // Tag pipe shifts every cycle so its depth matches the unit latency exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int s = 0; s < ACT_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int s = 1; s < ACT_LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  // Pointer follows the last winner; post_rst masks the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDW'(NUM_REQ - 1);
      post_rst <= 1'b1;
    end else begin
      post_rst <= 1'b0;
      if (gnt_any) ptr <= gnt_id;
    end
  end

  // Credits and response registers: set on grant/capture, cleared on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i])
          busy[i] <= 1'b1;
        else if (rsp_valid[i] && rsp_ready[i])
          busy[i] <= 1'b0;

        if (capture && (last_id == IDW'(i))) begin
          rsp_valid[i]                            <= 1'b1;
          rsp_data[i*DATA_WIDTH +: DATA_WIDTH]    <= act_o_data;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky protocol error when unit output and tag pipe disagree.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (mismatch)
      err <= 1'b1;
  end

endmodule

// File: tb/tb_act_share_arbiter.sv
// Directed self-checking bench for act_share_arbiter (4 requesters, 16-bit,
// latency 1) with a hard-sigmoid activation model in Q.5 format.
module tb_act_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_ready = '0;
  logic        act_en;
  logic        act_valid;
  logic [15:0] act_data;
  logic        act_o_valid;
  logic [15:0] act_o_data;
  logic        err;

  logic        unit_v = 1'b0;
  logic [15:0] unit_d = '0;
  logic        force_ov = 1'b0;
  logic        kill_ov = 1'b0;

  int checks = 0;
  int errors = 0;
  int gcount;
  logic [3:0] exp_gnt [8];

  always #5 clk = ~clk;

  act_share_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .ACT_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .act_en(act_en), .act_valid(act_valid), .act_data(act_data),
    .act_o_valid(act_o_valid), .act_o_data(act_o_data), .err(err)
  );

  // Hard sigmoid in Q.5: y = clamp(0.5 + x/4, 0, 1).
  function automatic logic [15:0] hsig(input logic [15:0] x);
    int xi;
    int y;
    xi = int'($signed(x));
    y  = 16 + (xi >>> 2);
    if (y < 0)  y = 0;
    if (y > 32) y = 32;
    return 16'(y);
  endfunction

  // One-cycle-latency activation unit model with fault-injection hooks.
  always @(posedge clk) begin
    unit_v <= act_valid;
    unit_d <= hsig(act_data);
  end

  assign act_o_valid = (unit_v & ~kill_ov) | force_ov;
  assign act_o_data  = unit_d;

  function automatic logic [15:0] rspd(input int i);
    return rsp_data[i*16 +: 16];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] valid, input logic [3:0] ready);
    i_en      = en;
    req_valid = valid;
    rsp_ready = ready;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
    rst = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req_data = {16'hFFE0, 16'h0040, 16'h0020, 16'h0000};
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset state
    step();
    doReset();
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("rst_rsp_valid", rsp_valid, 4'b0000);
    checkOutput("rst_rsp_data0", rspd(0), 16'h0000);
    checkOutput("rst_rsp_data3", rspd(3), 16'h0000);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_act_valid", act_valid, 1'b0);

    // Single request
    $display("[TB] single request");
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    checkOutput("single_ready", req_ready, 4'b0001);
    checkOutput("single_act_valid", act_valid, 1'b1);
    checkOutput("single_act_en", act_en, 1'b1);
    checkOutput("single_act_data", act_data, 16'h0000);
    step();
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("single_rsp_t1", rsp_valid, 4'b0000);
    step();
    applyStimulus(1'b1, 4'b0000, 4'b0001);
    checkOutput("single_rsp_t2", rsp_valid, 4'b0001);
    checkOutput("single_data_t2", rspd(0), 16'h0010);
    step();
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("single_rsp_t3", rsp_valid, 4'b0000);

    // Round-robin fairness
    $display("[TB] round robin");
    doReset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      applyStimulus(1'b1, 4'b1111, 4'b1111);
      checkOutput($sformatf("rr_grant_%0d", c), req_ready, exp_gnt[c]);
      if (c == 3) begin
        checkOutput("rr_rsp_t3", rsp_valid, 4'b0010);
        checkOutput("rr_data1", rspd(1), 16'h0018);
      end
      if (c == 5) begin
        checkOutput("rr_rsp_t5", rsp_valid, 4'b1000);
        checkOutput("rr_data3", rspd(3), 16'h0008);
      end
    end
    for (int c = 0; c < 4; c++) begin
      step();
      applyStimulus(1'b1, 4'b0000, 4'b1111);
    end
    checkOutput("rr_drained", rsp_valid, 4'b0000);

    // Backpressure on requester 1
    $display("[TB] backpressure");
    doReset();
    applyStimulus(1'b1, 4'b0010, 4'b1101);
    checkOutput("bp_grant1", req_ready, 4'b0010);
    gcount = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      applyStimulus(1'b1, 4'b1111, 4'b1101);
      checkOutput("bp_no_regrant", req_ready[1], 1'b0);
      if (req_ready != 4'b0000) gcount++;
      if (i >= 2) begin
        checkOutput("bp_hold_valid", rsp_valid[1], 1'b1);
        checkOutput("bp_hold_data", rspd(1), 16'h0018);
      end
    end
    checkOutput("bp_others_served", gcount, 10);
    step();
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    step();
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    checkOutput("bp_released", rsp_valid[1], 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      applyStimulus(1'b1, 4'b0000, 4'b1111);
    end
    checkOutput("bp_drained", rsp_valid, 4'b0000);

    // Enable gating
    $display("[TB] enable gating");
    doReset();
    applyStimulus(1'b1, 4'b0100, 4'b0000);
    checkOutput("en_grant2", req_ready, 4'b0100);
    checkOutput("en_act_data", act_data, 16'h0040);
    step();
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkOutput("en_off_ready", req_ready, 4'b0000);
    checkOutput("en_off_act_valid", act_valid, 1'b0);
    checkOutput("en_off_act_data", act_data, 16'h0000);
    step();
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkOutput("en_rsp2", rsp_valid, 4'b0100);
    checkOutput("en_data2", rspd(2), 16'h0020);
    checkOutput("en_off_ready2", req_ready, 4'b0000);
    step();
    applyStimulus(1'b0, 4'b1111, 4'b0100);
    checkOutput("en_off_ready3", req_ready, 4'b0000);
    step();
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    checkOutput("en_resume_ptr3", req_ready, 4'b1000);

    // Reset mid-flight, with a grant during the reset cycle
    $display("[TB] reset mid-flight");
    step();
    rst = 1'b1;
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    step();
    rst = 1'b0;
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    checkOutput("mr_rsp_valid", rsp_valid, 4'b0000);
    checkOutput("mr_err", err, 1'b0);
    checkOutput("mr_prio0", req_ready, 4'b0001);
    step();
    applyStimulus(1'b1, 4'b1000, 4'b0000);
    checkOutput("mr_busy3_cleared", req_ready, 4'b1000);
    checkOutput("mr_err_ignored", err, 1'b0);
    checkOutput("mr_rsp_t7", rsp_valid, 4'b0000);
    step();
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("mr_rsp_t8", rsp_valid, 4'b0001);
    checkOutput("mr_data0", rspd(0), 16'h0010);
    checkOutput("mr_err_t8", err, 1'b0);

    // Protocol error: spurious unit output
    $display("[TB] protocol error");
    doReset();
    force_ov = 1'b1;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
    force_ov = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("pe_err_set", err, 1'b1);
    checkOutput("pe_no_rsp", rsp_valid, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      step();
      applyStimulus(1'b1, 4'b0000, 4'b0000);
    end
    checkOutput("pe_err_sticky", err, 1'b1);
    checkOutput("pe_no_rsp_late", rsp_valid, 4'b0000);

    // Protocol error: missing unit output for a valid tag
    doReset();
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("pe2_err_clear", err, 1'b0);
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    checkOutput("pe2_grant0", req_ready, 4'b0001);
    step();
    kill_ov = 1'b1;
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    step();
    kill_ov = 1'b0;
    applyStimulus(1'b1, 4'b0001, 4'b0001);
    checkOutput("pe2_err_set", err, 1'b1);
    checkOutput("pe2_no_rsp", rsp_valid, 4'b0000);
    checkOutput("pe2_stuck", req_ready, 4'b0000);
    step();
    applyStimulus(1'b1, 4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
